// File: rtl/ppu_pkg.sv
// Shared PPU types: frame controller state encoding and IRQ stretcher counter width.
package ppu_pkg;

    typedef enum logic [1:0] {FC_SYNC, FC_HOLD, FC_DISP, FC_LATE} frame_state_t;

    localparam int IRQ_CNT_W = 4;

endpackage

// File: rtl/irq_stretch.sv
// Restartable pulse stretcher: a fire holds pulse high for exactly LEN cycles,
// and a fire arriving mid-pulse restarts the full length.
module irq_stretch
    import ppu_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic pulse
);

    logic [IRQ_CNT_W-1:0] remain;

    // remain counts the cycles still owed after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            remain <= '0;
            pulse  <= 1'b0;
        end else if (fire) begin
            remain <= IRQ_CNT_W'(LEN - 1);
            pulse  <= 1'b1;
        end else if (remain != '0) begin
            remain <= remain - IRQ_CNT_W'(1);
            pulse  <= 1'b1;
        end else begin
            pulse  <= 1'b0;
        end
    end

endmodule

// File: rtl/vram_frame_ctrl.sv
// Frame-level controller for the double-buffered VRAM: sequences the sync copy,
// gates row-RAM swaps, issues CPU write-permit IRQs and tracks late frames.
module vram_frame_ctrl
    import ppu_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int IRQ_LEN    = 4,
    parameter int MAX_LATE   = 3,
    parameter int FORCE_SYNC = 1,
    parameter int FRAME_W    = 16,
    parameter int LATE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank_start,
    input  logic               vblank_end_soon,
    input  logic               rowram_swap,
    input  logic [NUM_CH-1:0]  wr_busy,
    input  logic [NUM_CH-1:0]  irq_en,
    input  logic               sync_done,
    input  logic               err_clr,
    output logic               sync_start,
    output logic               sync_active,
    output logic               rowram_swap_disp,
    output logic [NUM_CH-1:0]  wr_irq,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [LATE_W-1:0]  late_cnt,
    output logic               sync_err,
    output logic               late_timeout
);

    frame_state_t state, state_next;

    logic       in_vblank;
    logic       missed_end;
    logic       fresh;
    logic [7:0] late_run;
    logic [8:0] late_run_inc;
    logic       any_busy;
    logic       end_evt;
    logic       fire;
    logic       set_err;
    logic       set_to;
    logic       bump_late;
    logic       clr_run;

    assign any_busy     = |wr_busy;
    assign end_evt      = vblank_end_soon & ~vblank_start;
    assign late_run_inc = {1'b0, late_run} + 9'd1;

    // missed_end remembers that the display area began while the copy was still
    // running, so the eventual sync_done skips HOLD and releases the CPU at once.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        set_err    = 1'b0;
        set_to     = 1'b0;
        bump_late  = 1'b0;
        clr_run    = 1'b0;
        case (state)
            FC_SYNC: begin
                if (sync_done) begin
                    if (missed_end || end_evt) begin
                        state_next = FC_DISP;
                        fire       = 1'b1;
                    end else begin
                        state_next = FC_HOLD;
                    end
                end else if (end_evt) begin
                    set_err = 1'b1;
                end
            end
            FC_HOLD: begin
                if (end_evt) begin
                    state_next = FC_DISP;
                    fire       = 1'b1;
                end
            end
            FC_DISP: begin
                if (vblank_start) begin
                    clr_run = 1'b1;
                    if (any_busy) begin
                        state_next = FC_LATE;
                        bump_late  = 1'b1;
                    end else begin
                        state_next = FC_SYNC;
                    end
                end
            end
            FC_LATE: begin
                if (vblank_start) begin
                    if (!any_busy) begin
                        state_next = FC_SYNC;
                    end else begin
                        bump_late = 1'b1;
                        if (FORCE_SYNC != 0 && late_run_inc >= 9'(MAX_LATE)) begin
                            state_next = FC_SYNC;
                            set_to     = 1'b1;
                        end
                    end
                end
            end
            default: state_next = FC_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FC_SYNC;
            fresh      <= 1'b1;
            sync_start <= 1'b0;
            missed_end <= 1'b0;
        end else begin
            state      <= state_next;
            fresh      <= 1'b0;
            sync_start <= fresh | (state != FC_SYNC && state_next == FC_SYNC);
            if (state_next != FC_SYNC)
                missed_end <= 1'b0;
            else if (set_err)
                missed_end <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_vblank    <= 1'b1;
            frame_cnt    <= '0;
            late_cnt     <= '0;
            late_run     <= '0;
            sync_err     <= 1'b0;
            late_timeout <= 1'b0;
        end else begin
            if (vblank_start)
                in_vblank <= 1'b1;
            else if (vblank_end_soon)
                in_vblank <= 1'b0;

            if (vblank_start)
                frame_cnt <= frame_cnt + FRAME_W'(1);

            if (bump_late && late_cnt != '1)
                late_cnt <= late_cnt + LATE_W'(1);

            if (bump_late)
                late_run <= clr_run ? 8'd1 : (late_run == 8'hFF ? late_run : late_run + 8'd1);
            else if (clr_run)
                late_run <= 8'd0;

            // A set in the same cycle as err_clr must survive.
            sync_err     <= set_err | (sync_err & ~err_clr);
            late_timeout <= set_to | (late_timeout & ~err_clr);
        end
    end

    assign sync_active      = (state == FC_SYNC) || (state == FC_HOLD);
    assign rowram_swap_disp = rowram_swap & ~in_vblank & ((state == FC_DISP) || (state == FC_LATE));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_irq
        irq_stretch #(.LEN(IRQ_LEN)) u_irq (
            .clk   (clk),
            .rst   (rst),
            .fire  (fire & irq_en[i]),
            .pulse (wr_irq[i])
        );
    end

endmodule

// File: tb/tb_vram_frame_ctrl.sv
// Bench for vram_frame_ctrl: two instances (forced sync on/off) share stimulus
// and are compared every cycle against a frame-behaviour reference model.
module tb_vram_frame_ctrl;

    localparam int NUM_CH   = 2;
    localparam int IRQ_LEN  = 4;
    localparam int MAX_LATE = 3;
    localparam int FRAME_W  = 16;
    localparam int LATE_W   = 8;

    localparam int M_SYNC = 0;
    localparam int M_HOLD = 1;
    localparam int M_DISP = 2;
    localparam int M_LATE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              vblank_start;
    logic              vblank_end_soon;
    logic              rowram_swap;
    logic              sync_done;
    logic              err_clr;
    logic [NUM_CH-1:0] wr_busy;
    logic [NUM_CH-1:0] irq_en;

    logic               start_w  [2];
    logic               active_w [2];
    logic               swap_w   [2];
    logic               err_w    [2];
    logic               to_w     [2];
    logic [NUM_CH-1:0]  irq_w    [2];
    logic [FRAME_W-1:0] frame_w  [2];
    logic [LATE_W-1:0]  late_w   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vram_frame_ctrl #(
            .NUM_CH     (NUM_CH),
            .IRQ_LEN    (IRQ_LEN),
            .MAX_LATE   (MAX_LATE),
            .FORCE_SYNC ((g == 0) ? 1 : 0),
            .FRAME_W    (FRAME_W),
            .LATE_W     (LATE_W)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .vblank_start     (vblank_start),
            .vblank_end_soon  (vblank_end_soon),
            .rowram_swap      (rowram_swap),
            .wr_busy          (wr_busy),
            .irq_en           (irq_en),
            .sync_done        (sync_done),
            .err_clr          (err_clr),
            .sync_start       (start_w[g]),
            .sync_active      (active_w[g]),
            .rowram_swap_disp (swap_w[g]),
            .wr_irq           (irq_w[g]),
            .frame_cnt        (frame_w[g]),
            .late_cnt         (late_w[g]),
            .sync_err         (err_w[g]),
            .late_timeout     (to_w[g])
        );
    end

    // Reference model state, one set per instance.
    int m_mode     [2];
    bit m_fresh    [2];
    bit m_start    [2];
    bit m_missed   [2];
    bit m_inv      [2];
    int m_frame    [2];
    int m_late     [2];
    int m_run      [2];
    bit m_err      [2];
    bit m_to       [2];
    int m_irq_left [2][NUM_CH];

    int vectors     = 0;
    int miscompares = 0;

    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            bit ves_eff, busy, fire, set_err, set_to, bump;
            int nxt;
            if (rst) begin
                m_mode[k]   = M_SYNC;
                m_fresh[k]  = 1'b1;
                m_start[k]  = 1'b0;
                m_missed[k] = 1'b0;
                m_inv[k]    = 1'b1;
                m_frame[k]  = 0;
                m_late[k]   = 0;
                m_run[k]    = 0;
                m_err[k]    = 1'b0;
                m_to[k]     = 1'b0;
                for (int i = 0; i < NUM_CH; i++) m_irq_left[k][i] = 0;
            end else begin
                ves_eff = vblank_end_soon && !vblank_start;
                busy    = (wr_busy != '0);
                fire    = 1'b0;
                set_err = 1'b0;
                set_to  = 1'b0;
                bump    = 1'b0;
                nxt     = m_mode[k];
                if (m_mode[k] == M_SYNC) begin
                    if (sync_done) begin
                        fire = m_missed[k] || ves_eff;
                        nxt  = fire ? M_DISP : M_HOLD;
                    end else if (ves_eff) begin
                        set_err = 1'b1;
                    end
                end else if (m_mode[k] == M_HOLD) begin
                    if (ves_eff) begin
                        nxt  = M_DISP;
                        fire = 1'b1;
                    end
                end else if (m_mode[k] == M_DISP) begin
                    if (vblank_start) begin
                        m_run[k] = 0;
                        if (busy) begin
                            nxt      = M_LATE;
                            bump     = 1'b1;
                            m_run[k] = 1;
                        end else begin
                            nxt = M_SYNC;
                        end
                    end
                end else begin
                    if (vblank_start) begin
                        if (!busy) begin
                            nxt = M_SYNC;
                        end else begin
                            bump     = 1'b1;
                            m_run[k] = m_run[k] + 1;
                            if (k == 0 && m_run[k] >= MAX_LATE) begin
                                nxt    = M_SYNC;
                                set_to = 1'b1;
                            end
                        end
                    end
                end
                m_start[k] = m_fresh[k] || (m_mode[k] != M_SYNC && nxt == M_SYNC);
                m_fresh[k] = 1'b0;
                if (nxt != M_SYNC) m_missed[k] = 1'b0;
                else if (set_err)  m_missed[k] = 1'b1;
                m_mode[k] = nxt;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (fire && irq_en[i])       m_irq_left[k][i] = IRQ_LEN;
                    else if (m_irq_left[k][i] > 0) m_irq_left[k][i] = m_irq_left[k][i] - 1;
                end
                if (vblank_start)         m_frame[k] = (m_frame[k] + 1) % (1 << FRAME_W);
                if (bump && m_late[k] < (1 << LATE_W) - 1) m_late[k] = m_late[k] + 1;
                if (vblank_start)         m_inv[k] = 1'b1;
                else if (vblank_end_soon) m_inv[k] = 1'b0;
                m_err[k] = set_err || (m_err[k] && !err_clr);
                m_to[k]  = set_to  || (m_to[k]  && !err_clr);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] irq_exp;
            irq_exp = '0;
            for (int i = 0; i < NUM_CH; i++) irq_exp[i] = (m_irq_left[k][i] > 0);
            checkOutput($sformatf("sync_start[%0d]", k),   32'(start_w[k]),  32'(m_start[k]));
            checkOutput($sformatf("sync_active[%0d]", k),  32'(active_w[k]),
                        32'(m_mode[k] == M_SYNC || m_mode[k] == M_HOLD));
            checkOutput($sformatf("swap_disp[%0d]", k),    32'(swap_w[k]),
                        32'(rowram_swap && !m_inv[k] && (m_mode[k] == M_DISP || m_mode[k] == M_LATE)));
            checkOutput($sformatf("wr_irq[%0d]", k),       32'(irq_w[k]),    irq_exp);
            checkOutput($sformatf("frame_cnt[%0d]", k),    32'(frame_w[k]),  32'(m_frame[k]));
            checkOutput($sformatf("late_cnt[%0d]", k),     32'(late_w[k]),   32'(m_late[k]));
            checkOutput($sformatf("sync_err[%0d]", k),     32'(err_w[k]),    32'(m_err[k]));
            checkOutput($sformatf("late_timeout[%0d]", k), 32'(to_w[k]),     32'(m_to[k]));
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic pulse(input bit vs, input bit ves, input bit sd, input bit ec);
        vblank_start    = vs;
        vblank_end_soon = ves;
        sync_done       = sd;
        err_clr         = ec;
        applyStimulus();
        vblank_start    = 1'b0;
        vblank_end_soon = 1'b0;
        sync_done       = 1'b0;
        err_clr         = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vblank_start = 1'b0; vblank_end_soon = 1'b0; sync_done = 1'b0;
        err_clr = 1'b0; rowram_swap = 1'b1; wr_busy = '0; irq_en = 2'b11;

        // Reset, then the first sync: sync_done at cycle 10, vblank_end_soon at 20.
        idle(2);
        rst = 1'b0;
        applyStimulus();
        checkOutput("start_after_reset", 32'(start_w[0]), 32'd1);
        idle(8);
        pulse(0, 0, 1, 0);
        checkOutput("hold_active", 32'(active_w[0]), 32'd1);
        idle(9);
        pulse(0, 1, 0, 0);
        checkOutput("irq_on_release", 32'(irq_w[0]), 32'h3);
        checkOutput("active_off_disp", 32'(active_w[0]), 32'd0);
        idle(5);

        // Busy writer at vblank_start makes the frame late; idle one next time syncs.
        wr_busy = 2'b10;
        pulse(1, 0, 0, 0);
        checkOutput("late_cnt_one", 32'(late_w[0]), 32'd1);
        checkOutput("no_start_late", 32'(start_w[0]), 32'd0);
        wr_busy = 2'b00;
        idle(2); pulse(0, 1, 0, 0); idle(3);
        pulse(1, 0, 0, 0);
        checkOutput("start_after_late", 32'(start_w[0]), 32'd1);
        checkOutput("frame_two", 32'(frame_w[0]), 32'd2);
        idle(2); pulse(0, 0, 1, 0); idle(2); pulse(0, 1, 0, 0); idle(4);

        // Persistent busy: instance 0 forces a sync, instance 1 stays late and saturates.
        wr_busy = 2'b01;
        repeat (2) begin
            pulse(1, 0, 0, 0); idle(2); pulse(0, 1, 0, 0); idle(2);
        end
        pulse(1, 0, 0, 0);
        checkOutput("forced_timeout", 32'(to_w[0]), 32'd1);
        checkOutput("forced_start", 32'(start_w[0]), 32'd1);
        checkOutput("forced_late_cnt", 32'(late_w[0]), 32'd4);
        checkOutput("noforce_stays_late", 32'(active_w[1]), 32'd0);
        checkOutput("noforce_no_timeout", 32'(to_w[1]), 32'd0);
        repeat (255) begin
            pulse(1, 0, 0, 0); applyStimulus();
        end
        checkOutput("late_cnt_saturated", 32'(late_w[1]), 32'd255);

        // Copy overrun: vblank_end_soon before sync_done, then clears.
        wr_busy = 2'b00;
        rst = 1'b1; applyStimulus(); rst = 1'b0;
        idle(3);
        pulse(0, 1, 0, 0);
        checkOutput("sync_err_set", 32'(err_w[0]), 32'd1);
        checkOutput("no_irq_overrun", 32'(irq_w[0]), 32'd0);
        idle(4);
        pulse(0, 0, 1, 0);
        checkOutput("irq_after_late_done", 32'(irq_w[0]), 32'h3);
        checkOutput("disp_after_late_done", 32'(active_w[0]), 32'd0);
        idle(4);
        pulse(0, 0, 0, 1);
        checkOutput("sync_err_cleared", 32'(err_w[0]), 32'd0);
        pulse(1, 0, 0, 0); idle(2);
        pulse(0, 1, 0, 1);
        checkOutput("set_beats_clear", 32'(err_w[0]), 32'd1);
        idle(2); pulse(0, 0, 1, 0); idle(5);

        // Reset while holding.
        pulse(1, 0, 0, 0); idle(2); pulse(0, 0, 1, 0); idle(2);
        rst = 1'b1; applyStimulus();
        checkOutput("rst_active", 32'(active_w[0]), 32'd1);
        checkOutput("rst_frame", 32'(frame_w[0]), 32'd0);
        checkOutput("rst_irq", 32'(irq_w[0]), 32'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_fresh_start", 32'(start_w[0]), 32'd1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 499) == 0);
            vblank_start    = ($urandom_range(0, 15) == 0);
            vblank_end_soon = ($urandom_range(0, 15) == 0);
            sync_done       = ($urandom_range(0, 11) == 0);
            err_clr         = ($urandom_range(0, 31) == 0);
            rowram_swap     = 1'($urandom);
            wr_busy         = NUM_CH'($urandom);
            irq_en          = NUM_CH'($urandom);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
